// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-cycle data-memory port between the CPU datapath and a
//   debug/loader port. Each access is a fixed three-phase sequence:
//     IDLE : pick a requester, latch its addr/wdata/we
//     ACC  : drive the memory port from the latched copy
//     DONE : one-cycle ack to the granted port
//   so a request sampled at edge N sees its memory cycle in N+1 and its ack
//   in N+2.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                   undefined -> fixed priority, CPU always wins
//
// Ports:
//   clock, Reset          clock / async active-low reset
//   cpu_req/we/addr/wdata CPU request side
//   cpu_rdata/ack/stall   CPU load data, completion pulse, PC hold
//   dbg_req/we/addr/wdata debug request side
//   dbg_rdata/ack         debug load data, completion pulse
//   mem_addr/wdata        shared memory address / store data (0 outside ACC)
//   mem_memwrite/memread  shared memory strobes (one-hot in ACC, else 0)
//   mem_readdata          shared memory load data, sampled at end of ACC
// -----------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter (
    input  logic        clock,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        grant_dbg_q;   // 1: access in flight belongs to debug port
    logic [31:0] mem_addr_q;    // latched at grant, doubles as the port driver
    logic [31:0] mem_wdata_q;
    logic        mem_wr_q;
    logic        mem_rd_q;
    logic [31:0] cpu_rdata_q;
    logic [31:0] dbg_rdata_q;
    logic        cpu_ack_q;
    logic        dbg_ack_q;
`ifdef DMEM_ARB_RR_EN
    logic        last_dbg_q;    // 1: most recent grant went to debug port
`endif

    // Grant selection for the current IDLE cycle.
    logic        pick_dbg_d;
    logic        sel_we_d;
    logic [31:0] sel_addr_d;
    logic [31:0] sel_wdata_d;

    always_comb begin
        pick_dbg_d = 1'b0;
`ifdef DMEM_ARB_RR_EN
        // On a tie, hand the port to whoever did not have it last.
        if (cpu_req && dbg_req) pick_dbg_d = ~last_dbg_q;
        else                    pick_dbg_d = dbg_req;
`else
        pick_dbg_d = dbg_req & ~cpu_req;
`endif
        sel_we_d    = pick_dbg_d ? dbg_we    : cpu_we;
        sel_addr_d  = pick_dbg_d ? dbg_addr  : cpu_addr;
        sel_wdata_d = pick_dbg_d ? dbg_wdata : cpu_wdata;
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            grant_dbg_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_dbg_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        grant_dbg_q <= pick_dbg_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        mem_wr_q    <= sel_we_d;
                        mem_rd_q    <= ~sel_we_d;
`ifdef DMEM_ARB_RR_EN
                        last_dbg_q  <= pick_dbg_d;
`endif
                        state_q     <= ACC;
                    end
                end
                ACC: begin
                    // Loads land in the owner's rdata; stores leave it alone.
                    if (mem_rd_q) begin
                        if (grant_dbg_q) dbg_rdata_q <= mem_readdata;
                        else             cpu_rdata_q <= mem_readdata;
                    end
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_wr_q    <= 1'b0;
                    mem_rd_q    <= 1'b0;
                    cpu_ack_q   <= ~grant_dbg_q;
                    dbg_ack_q   <= grant_dbg_q;
                    state_q     <= DONE;
                end
                DONE: begin
                    cpu_ack_q <= 1'b0;
                    dbg_ack_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_memwrite = mem_wr_q;
    assign mem_memread  = mem_rd_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign dbg_rdata    = dbg_rdata_q;
    assign cpu_ack      = cpu_ack_q;
    assign dbg_ack      = dbg_ack_q;

    // Hold the PC from request until the completion pulse.
    assign cpu_stall    = cpu_req & ~cpu_ack_q;

endmodule

`default_nettype wire
